// File: rtl/spi_slave_responder_if.sv
// SPI pin bundle between a mode-0 master and the responder.
// The master drives SCK/SS/MOSI. The slave answers on MISO.
interface spi_slave_responder_if;
    logic SCK;
    logic SS;
    logic MOSI;
    logic MISO;

    modport master (output SCK, output SS, output MOSI, input MISO);
    modport slave  (input SCK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversamples SCK/SS/MOSI in clk, answers from a 4-word bank, captures 4 rx slots.
// Latency: 4 clk from a raw pin edge to MISO/rx_valid/frame_done. Optional SPI_SLAVE_LOOPBACK_EN echoes rx words.
// Backpressure: none; the master's SCK phases of at least 6 clk pace the block.
module spi_slave_responder #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_slave_responder_if.slave spi,
    input  logic [DATA_BITS-1:0] resp_word0,
    input  logic [DATA_BITS-1:0] resp_word1,
    input  logic [DATA_BITS-1:0] resp_word2,
    input  logic [DATA_BITS-1:0] resp_word3,
    output logic [DATA_BITS-1:0] rx_word0,
    output logic [DATA_BITS-1:0] rx_word1,
    output logic [DATA_BITS-1:0] rx_word2,
    output logic [DATA_BITS-1:0] rx_word3,
    output logic                 rx_valid,
    output logic [1:0]           rx_index,
    output logic                 frame_done
);
    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic sck_s1, sck_s2, sck_h;
    logic ss_s1, ss_s2, ss_h;
    logic mosi_s1, mosi_s2, mosi_h;
    logic sck_rise_q, sck_fall_q, ss_fall_q, ss_rise_q;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [1:0]           ptr;
    logic                 done_flag;
    logic [DATA_BITS-2:0] tx_sr;
    logic [DATA_BITS-2:0] rx_sr;
    logic                 miso_q;
    logic [DATA_BITS-1:0] rx_mem [4];
    logic [DATA_BITS-1:0] resp_sel;
    logic [DATA_BITS-1:0] next_tx;
    logic [DATA_BITS-1:0] rx_full;

    // Sync chains clear to 0 so an SS held low through reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1     <= 1'b0;
            sck_s2     <= 1'b0;
            sck_h      <= 1'b0;
            ss_s1      <= 1'b0;
            ss_s2      <= 1'b0;
            ss_h       <= 1'b0;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            mosi_h     <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            ss_fall_q  <= 1'b0;
            ss_rise_q  <= 1'b0;
        end else begin
            sck_s1     <= spi.SCK;
            sck_s2     <= sck_s1;
            sck_h      <= sck_s2;
            ss_s1      <= spi.SS;
            ss_s2      <= ss_s1;
            ss_h       <= ss_s2;
            mosi_s1    <= spi.MOSI;
            mosi_s2    <= mosi_s1;
            mosi_h     <= mosi_s2;
            sck_rise_q <= sck_s2 & ~sck_h;
            sck_fall_q <= ~sck_s2 & sck_h;
            ss_fall_q  <= ~ss_s2 & ss_h;
            ss_rise_q  <= ss_s2 & ~ss_h;
        end
    end

    always_comb begin
        resp_sel = resp_word0;
        case (ptr)
            2'd0: resp_sel = resp_word0;
            2'd1: resp_sel = resp_word1;
            2'd2: resp_sel = resp_word2;
            2'd3: resp_sel = resp_word3;
            default: resp_sel = resp_word0;
        endcase
    end

`ifdef SPI_SLAVE_LOOPBACK_EN
    // Word boundaries always follow a capture, so ptr-1 is the slot just written.
    assign next_tx = rx_mem[ptr - 2'd1];
`else
    assign next_tx = resp_sel;
`endif

    // mosi_h lines up with the same sync stage that produced sck_rise_q.
    assign rx_full = {rx_sr, mosi_h};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ptr        <= 2'd0;
            done_flag  <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            miso_q     <= 1'b0;
            rx_valid   <= 1'b0;
            rx_index   <= 2'd0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) rx_mem[i] <= '0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall_q) begin
                        tx_sr     <= resp_word0[DATA_BITS-2:0];
                        miso_q    <= resp_word0[DATA_BITS-1];
                        ptr       <= 2'd0;
                        bit_cnt   <= '0;
                        rx_sr     <= '0;
                        done_flag <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise_q) begin
                        frame_done <= done_flag;
                        miso_q     <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= IDLE;
                    end else if (sck_rise_q) begin
                        rx_sr <= rx_full[DATA_BITS-2:0];
                        if (bit_cnt == CW'(DATA_BITS - 1)) begin
                            rx_mem[ptr] <= rx_full;
                            rx_valid    <= 1'b1;
                            rx_index    <= ptr;
                            done_flag   <= 1'b1;
                            bit_cnt     <= '0;
                            ptr         <= ptr + 2'd1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall_q) begin
                        if (bit_cnt != '0) begin
                            miso_q <= tx_sr[DATA_BITS-2];
                            tx_sr  <= tx_sr << 1;
                        end else begin
                            miso_q <= next_tx[DATA_BITS-1];
                            tx_sr  <= next_tx[DATA_BITS-2:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi.MISO = miso_q;
    assign rx_word0 = rx_mem[0];
    assign rx_word1 = rx_mem[1];
    assign rx_word2 = rx_mem[2];
    assign rx_word3 = rx_mem[3];

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a table of whole frames plus hand-written partial/reset/empty cases.
// A scoreboard queue holds expected captures, which are popped when rx_valid fires.
module tb_spi_slave_responder;
    localparam int PH = 8;

`ifdef SPI_SLAVE_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_responder_if spi_if();

    logic [7:0] resp0, resp1, resp2, resp3;
    logic [7:0] rx0, rx1, rx2, rx3;
    logic       rx_valid;
    logic [1:0] rx_index;
    logic       frame_done;
    logic [7:0] rxw [4];

    spi_slave_responder #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi_if),
        .resp_word0 (resp0),
        .resp_word1 (resp1),
        .resp_word2 (resp2),
        .resp_word3 (resp3),
        .rx_word0   (rx0),
        .rx_word1   (rx1),
        .rx_word2   (rx2),
        .rx_word3   (rx3),
        .rx_valid   (rx_valid),
        .rx_index   (rx_index),
        .frame_done (frame_done)
    );

    assign rxw[0] = rx0;
    assign rxw[1] = rx1;
    assign rxw[2] = rx2;
    assign rxw[3] = rx3;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
    } exp_t;

    typedef struct packed {
        logic [2:0]      n;
        logic [0:4][7:0] tx;
        logic [0:3][7:0] resp;
        logic [0:4][7:0] exp_miso;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] mdl [4];
    logic [1:0] ptr_m;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rv_cnt = 0;
    int fd_cnt = 0;
    int last_rise_cyc = 0;
    int ss_rise_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every capture and checks pulse latencies.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_valid_unexpected: got index %0d data %0h, expected no capture", rx_index, rxw[rx_index]);
            end else begin
                e = exp_q.pop_front();
                chk("rx_index", 32'(rx_index), 32'(e.idx));
                chk("rx_word_at_capture", 32'(rxw[e.idx]), 32'(e.dat));
                chk("rx_valid_latency", 32'(cyc - last_rise_cyc), 32'd4);
            end
        end
        if (frame_done) begin
            fd_cnt++;
            chk("frame_done_latency", 32'(cyc - ss_rise_cyc), 32'd4);
            if (rx_valid) begin
                total++;
                bad++;
                $display("FAIL pulse_overlap: got rx_valid=1 frame_done=1, expected never both");
            end
        end
    end

    task automatic ss_fall();
        @(negedge clk);
        spi_if.SS = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    task automatic ss_rise();
        repeat (PH) @(negedge clk);
        spi_if.SS = 1'b1;
        ss_rise_cyc = cyc;
        repeat (2 * PH) @(negedge clk);
    endtask

    // Mode-0 master: data changes while SCK is low, MISO is sampled just before the rise.
    task automatic xfer_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_if.MOSI = w[7-b];
            repeat (PH) @(negedge clk);
            got = {got[6:0], spi_if.MISO};
            spi_if.SCK = 1'b1;
            last_rise_cyc = cyc;
            repeat (PH) @(negedge clk);
            spi_if.SCK = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] w, output logic [7:0] got);
        exp_q.push_back({ptr_m, w});
        mdl[ptr_m] = w;
        ptr_m = ptr_m + 2'd1;
        xfer_bits(w, 8, got);
    endtask

    task automatic chk_rx_words(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_rx_word%0d", tag, k), 32'(rxw[k]), 32'(mdl[k]));
    endtask

    vec_t       vt [4];
    logic [7:0] got;
    int         rv0, fd0;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{n: 3'd4, tx: {8'hFA, 8'hFB, 8'hFC, 8'hFE, 8'h00},
                  resp: {8'hFA, 8'hFB, 8'hFC, 8'hFE},
                  exp_miso: LB ? {8'hFA, 8'hFA, 8'hFB, 8'hFC, 8'h00}
                               : {8'hFA, 8'hFB, 8'hFC, 8'hFE, 8'h00}};
        vt[1] = '{n: 3'd5, tx: {8'h11, 8'h22, 8'h33, 8'h44, 8'h55},
                  resp: {8'hA1, 8'hB2, 8'hC3, 8'hD4},
                  exp_miso: LB ? {8'hA1, 8'h11, 8'h22, 8'h33, 8'h44}
                               : {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1}};
        vt[2] = '{n: 3'd4, tx: {8'h01, 8'h02, 8'h03, 8'h04, 8'h00},
                  resp: {8'hF0, 8'hF1, 8'hF2, 8'hF3},
                  exp_miso: LB ? {8'hF0, 8'h01, 8'h02, 8'h03, 8'h00}
                               : {8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h00}};
        vt[3] = '{n: 3'd1, tx: {8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
                  resp: {8'h96, 8'h00, 8'h00, 8'h00},
                  exp_miso: {8'h96, 8'h00, 8'h00, 8'h00, 8'h00}};

        spi_if.SCK = 1'b0;
        spi_if.SS = 1'b1;
        spi_if.MOSI = 1'b0;
        {resp0, resp1, resp2, resp3} = '0;
        for (int k = 0; k < 4; k++) mdl[k] = 8'h00;
        ptr_m = 2'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("reset_miso", 32'(spi_if.MISO), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_index", 32'(rx_index), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk_rx_words("reset");
        repeat (PH) @(negedge clk);

        // Partial second word is dropped; slot 1 keeps its reset value.
        resp0 = 8'hC3;
        resp1 = 8'h5A;
        rv0 = rv_cnt;
        fd0 = fd_cnt;
        ss_fall();
        ptr_m = 2'd0;
        send_word(8'hA5, got);
        chk("partial_miso_word0", 32'(got), 32'hC3);
        xfer_bits(8'hFF, 3, got);
        ss_rise();
        chk("partial_rx_valid_count", 32'(rv_cnt - rv0), 32'd1);
        chk("partial_frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        chk("partial_miso_idle", 32'(spi_if.MISO), 32'd0);
        chk_rx_words("partial");

        for (int v = 0; v < 4; v++) begin
            {resp0, resp1, resp2, resp3} = vt[v].resp;
            fd0 = fd_cnt;
            ss_fall();
            ptr_m = 2'd0;
            for (int w = 0; w < int'(vt[v].n); w++) begin
                send_word(vt[v].tx[w], got);
                chk($sformatf("vec%0d_miso_word%0d", v, w), 32'(got), 32'(vt[v].exp_miso[w]));
            end
            ss_rise();
            chk($sformatf("vec%0d_frame_done_count", v), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("vec%0d_miso_idle", v), 32'(spi_if.MISO), 32'd0);
            chk($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
            chk_rx_words($sformatf("vec%0d", v));
        end

        // Empty frame: SS low with no SCK.
        rv0 = rv_cnt;
        fd0 = fd_cnt;
        @(negedge clk);
        spi_if.SS = 1'b0;
        repeat (20) @(negedge clk);
        spi_if.SS = 1'b1;
        ss_rise_cyc = cyc;
        repeat (2 * PH) @(negedge clk);
        chk("empty_frame_done_count", 32'(fd_cnt - fd0), 32'd0);
        chk("empty_rx_valid_count", 32'(rv_cnt - rv0), 32'd0);

        // Reset mid-frame with SS held low, then keep clocking SCK.
        rv0 = rv_cnt;
        fd0 = fd_cnt;
        resp0 = 8'hE7;
        ss_fall();
        xfer_bits(8'h96, 4, got);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) mdl[k] = 8'h00;
        xfer_bits(8'h69, 8, got);
        repeat (PH) @(negedge clk);
        chk("rst_mid_rx_valid_count", 32'(rv_cnt - rv0), 32'd0);
        chk("rst_mid_frame_done_count", 32'(fd_cnt - fd0), 32'd0);
        chk("rst_mid_miso", 32'(spi_if.MISO), 32'd0);
        chk("rst_mid_rx_index", 32'(rx_index), 32'd0);
        chk_rx_words("rst_mid");

        spi_if.SS = 1'b1;
        repeat (2 * PH) @(negedge clk);
        resp0 = 8'h77;
        fd0 = fd_cnt;
        ss_fall();
        ptr_m = 2'd0;
        send_word(8'h42, got);
        chk("after_rst_miso", 32'(got), 32'h77);
        ss_rise();
        chk("after_rst_frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        chk_rx_words("after_rst");

        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

Synthesizable SPI peripheral (mode 0, MSB first) that sits on the far end of the bus driven by `spi_controller`. It consumes `SCK`, `SS` and `MOSI`, answers on `MISO` from a bank of four response words, and captures up to four received words per frame. It runs entirely in the system clock domain by oversampling the SPI pins. It replaces the behavioural slave model currently used to exercise the controller, so the same loop can be closed on the FPGA.

## Interface
- `DATA_BITS`, 8: word width in bits. Legal range is 2..32.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `SCK`  in  1: SPI clock from the master. Asynchronous to `clk`; idle low.
- `SS`  in  1: slave select, active low. Asynchronous.
- `MOSI`  in  1: master-out data. Asynchronous.
- `MISO`  out  1: slave-out data.
- `resp_word0..3`  in  DATA_BITS each: response bank. Each word is sampled when its transmission is loaded.
- `rx_word0..3`  out  DATA_BITS each: last word received in each slot.
- `rx_valid`  out  1: one-cycle pulse when a full word is captured.
- `rx_index`  out  2: slot written by the current `rx_valid`.
- `frame_done`  out  1: one-cycle pulse at frame end, issued only if at least one word completed.

## Operation
- Input conditioning:
  - `SCK`, `SS` and `MOSI` each pass through a 2-FF synchronizer, followed by one history register used for edge detection.
  - `MOSI` goes through the same path as `SCK`, so it is sampled with the synchronized `SCK` rising edge.
- State machine `IDLE` → `SHIFT` → `IDLE`:
  - `IDLE`: `MISO`=0 and the bit counter is 0. On a synchronized `SS` fall: load `resp_word0` into the TX shift register, drive its MSB on `MISO`, set the word pointer to 0, clear the completed-word flag, and go to `SHIFT`.
  - `SHIFT`, SCK rise: shift the synchronized `MOSI` into the RX shift register LSB and increment the bit counter.
  - `SHIFT`, bit counter reaches `DATA_BITS` on that rise: write the assembled word to `rx_word[ptr]`, pulse `rx_valid` with `rx_index`=ptr, set the completed-word flag, reset the bit counter, and increment ptr modulo 4.
  - `SHIFT`, SCK fall with the bit counter nonzero: shift the TX register left and drive the new MSB.
  - `SHIFT`, SCK fall with the bit counter 0 (word boundary): load `resp_word[ptr]` and drive its MSB.
  - `SHIFT`, synchronized `SS` rise: discard any partial word without pulsing `rx_valid`. Pulse `frame_done` if the completed-word flag is set, then go to `IDLE` and drive `MISO`=0.
- Boundary rules:
  - A fifth word in one frame wraps ptr to 0 and overwrites `rx_word0`; it transmits `resp_word0`.
  - `SCK` edges while in `IDLE` are ignored.
  - If `SS` fall and `SCK` rise are detected in the same cycle, the `SS` fall is handled and the `SCK` rise is ignored.
  - If `SS` rise and `SCK` rise are detected in the same cycle, `SS` wins and no word is completed.
  - Reset mid-frame clears everything and forces `IDLE`. If `SS` is still low after reset, the block stays in `IDLE` until a fresh `SS` fall is detected; it requires seeing `SS` high first.
  - `rx_word*` values are held across frames and change only on capture or reset.
- Reset values: `MISO`=0, `rx_word0..3`=0, `rx_valid`=0, `rx_index`=0, `frame_done`=0, state `IDLE`, all counters 0.

## Timing
- Edge-detect latency is 3 `clk` cycles from a raw pin edge to the internal event.
- `MISO` updates 3 cycles after the raw `SS` fall or `SCK` fall, plus 1 register cycle. Total: 4 cycles.
- `rx_valid` is asserted 4 cycles after the raw `SCK` rise of the last bit.
- `frame_done` is asserted 4 cycles after the raw `SS` rise.
- Master constraints:
  - `SCK` high and low phases are each ≥ 6 `clk` cycles.
  - First `SCK` rise occurs ≥ 6 cycles after the `SS` fall.
  - `SS` rise occurs ≥ 6 cycles after the last `SCK` fall.
  - `SS` stays high ≥ 4 cycles between frames.
- `rx_valid` and `frame_done` never assert in the same cycle, because of the ≥6-cycle spacing.

## Configuration
- `SPI_SLAVE_LOOPBACK_EN`:
  - Defined: at each word boundary after the first, the TX register loads the word just received, `rx_word[ptr-1]`, instead of `resp_word[ptr]`. The first word of a frame still comes from `resp_word0`. The master therefore reads back its own words delayed by one slot.
  - Undefined: the TX register always loads from the `resp_word0..3` bank.

## Test plan
- Nominal 4-word frame:
  - Stimulus: reset 2 cycles; master sends FA, FB, FC, FE; responses are FA, FB, FC, FE; SCK phase 8 cycles.
  - Required response: master receives FA, FB, FC, FE; `rx_word0..3`=FA, FB, FC, FE; four `rx_valid` pulses with index 0..3; one `frame_done`.
- Partial word:
  - Stimulus: send 8'hA5, then 3 bits of a second word, then raise `SS`.
  - Required response: one `rx_valid`; `rx_word1` unchanged at 0; `frame_done` pulses; `MISO`=0 in `IDLE`.
- Wrap:
  - Stimulus: 5 words 11, 22, 33, 44, 55 in one frame.
  - Required response: `rx_word0`=55 and `rx_index` sequence 0, 1, 2, 3, 0; the fifth word transmits `resp_word0`.
- Reset mid-frame:
  - Stimulus: assert `reset` after 4 bits with `SS` low; keep clocking `SCK` with `SS` low.
  - Required response: no `rx_valid`; outputs at reset values; a normal frame after `SS` high→low works.
- Empty frame:
  - Stimulus: `SS` low for 20 cycles with no `SCK`, then high.
  - Required response: no `frame_done`, no `rx_valid`.
- Loopback:
  - Stimulus: with `SPI_SLAVE_LOOPBACK_EN` defined, master sends 01, 02, 03, 04; responses are F0..F3.
  - Required response: master receives F0, 01, 02, 03.
